spart_rx: RTL and testbench

SPART_RX -- requirements
Module: spart_rx

---
 rtl/spart_rx_if.sv | 24 ++
 rtl/spart_rx.sv | 140 ++++++++++++++
 tb/tb_spart_rx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_rx_if.sv
// Receive-side bundle of the SPART receiver: baud tick, serial line, read handshake and status.
// The master end (consumer/testbench) drives the line and acknowledges; the slave end is the receiver.
interface spart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 enable;
    logic                 rxd;
    logic                 rd_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 framing_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output enable, rxd, rd_ack,
        input  rx_data, rda, framing_err, overrun, busy
    );

    modport slave (
        input  enable, rxd, rd_ack,
        output rx_data, rda, framing_err, overrun, busy
    );
endinterface

// File: rtl/spart_rx.sv
// SPART receiver: oversampled 8N1-style deserializer with mid-bit sampling, a data-available
// flag, framing-error and overrun status, and a read acknowledge that clears the status.
module spart_rx #(
    parameter int DATA_BITS = 8,
    parameter int OSR       = 16
) (
    input  logic      clk,
    input  logic      rst,
    spart_rx_if.slave bus
);
    localparam int CNT_W = $clog2(OSR);
    localparam int IDX_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OSR / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(DATA_BITS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rda_q, rda_d;
    logic                 framing_err_q, framing_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 sync1_q, sync1_d;
    logic                 rxs_q, rxs_d;
    logic                 done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rda_q         <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
            sync1_q       <= 1'b1;
            rxs_q         <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rda_q         <= rda_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
            sync1_q       <= sync1_d;
            rxs_q         <= rxs_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rda_d         = rda_q;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;
        done          = 1'b0;
        sync1_d       = bus.rxd;
        rxs_d         = sync1_q;

        if (bus.enable) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        state_d = START;
                        cnt_d   = CNT_W'(1);
                    end
                end
                START: begin
                    // Half a bit after the falling edge the line must still be low,
                    // otherwise the edge was a glitch and is silently dropped.
                    if (cnt_q == CNT_HALF) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rxs_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_d                = shift_q >> 1;
                        shift_d[DATA_BITS-1]   = rxs_q;
                        cnt_d                  = '0;
                        idx_d                  = idx_q + IDX_W'(1);
                        if (idx_d == IDX_FULL) begin
                            idx_d   = '0;
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a start edge in the second half is caught.
                    if (cnt_q == CNT_LAST) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A completing frame takes precedence over a coincident acknowledge.
        if (done) begin
            rx_data_d     = shift_q;
            rda_d         = 1'b1;
            framing_err_d = ~rxs_q;
            overrun_d     = rda_q & ~bus.rd_ack;
        end else if (bus.rd_ack && rda_q) begin
            rda_d         = 1'b0;
            framing_err_d = 1'b0;
            overrun_d     = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rda         = rda_q;
    assign bus.framing_err = framing_err_q;
    assign bus.overrun     = overrun_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: randomized serial frames checked every cycle against a tick-position
// model of the receiver, plus fixed scenarios with hand-computed expected values.
module tb_spart_rx;
    localparam int DATA_BITS = 8;
    localparam int OSR       = 16;

    logic clk;
    logic rst;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    bit   started  = 0;
    bit   rand_ack = 0;

    spart_rx_if #(.DATA_BITS(DATA_BITS)) bus ();

    spart_rx #(.DATA_BITS(DATA_BITS), .OSR(OSR)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame model: pos counts enable ticks since the start edge was seen; the start bit is
    // verified at pos OSR/2, data bit k at OSR/2 + OSR*(k+1), the stop bit one bit later.
    typedef struct packed {
        logic [1:0]           pipe;
        logic                 active;
        logic [31:0]          pos;
        logic [DATA_BITS-1:0] bits;
        logic [DATA_BITS-1:0] data;
        logic                 rda;
        logic                 fe;
        logic                 ov;
        logic                 done;
    } model_t;

    model_t m_q;

    function automatic model_t model_step(model_t s, logic r, logic en, logic d, logic ack);
        model_t n;
        logic   rxs;
        int     p;
        int     k;
        n      = s;
        n.done = 1'b0;
        if (r) begin
            n      = '0;
            n.pipe = 2'b11;
            return n;
        end
        rxs    = s.pipe[1];
        n.pipe = {s.pipe[0], d};
        if (en) begin
            if (s.active) begin
                p     = int'(s.pos) + 1;
                n.pos = p;
                if (p == OSR / 2) begin
                    if (rxs) n.active = 1'b0;
                end else if (p > OSR / 2 && ((p - OSR / 2) % OSR) == 0) begin
                    k = (p - OSR / 2) / OSR;
                    if (k <= DATA_BITS) begin
                        n.bits[k-1] = rxs;
                    end else begin
                        n.done   = 1'b1;
                        n.active = 1'b0;
                    end
                end
            end else if (!rxs) begin
                n.active = 1'b1;
                n.pos    = '0;
            end
        end
        if (n.done) begin
            n.data = n.bits;
            n.rda  = 1'b1;
            n.fe   = ~rxs;
            n.ov   = s.rda & ~ack;
        end else if (ack && s.rda) begin
            n.rda = 1'b0;
            n.fe  = 1'b0;
            n.ov  = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk) m_q <= model_step(m_q, rst, bus.enable, bus.rxd, bus.rd_ack);

    always @(negedge clk) begin
        if (started) begin
            chk_cnt++;
            if ({bus.rx_data, bus.rda, bus.framing_err, bus.overrun, bus.busy} ===
                {m_q.data, m_q.rda, m_q.fe, m_q.ov, m_q.active}) begin
                pass_cnt++;
            end else begin
                $display("FAIL cycle t=%0t got data=%h rda=%b fe=%b ov=%b busy=%b want data=%h rda=%b fe=%b ov=%b busy=%b",
                         $time, bus.rx_data, bus.rda, bus.framing_err, bus.overrun, bus.busy,
                         m_q.data, m_q.rda, m_q.fe, m_q.ov, m_q.active);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s got %h want %h", name, act, exp);
    endtask

    // One enable pulse; optionally acknowledge on exactly the tick that completes a frame.
    task automatic tick(input bit ack_on_done);
        model_t pk;
        logic   a;
        @(negedge clk);
        bus.enable = 1'b1;
        a = rand_ack && ($urandom_range(0, 29) == 0);
        if (ack_on_done) begin
            pk = model_step(m_q, 1'b0, 1'b1, bus.rxd, 1'b0);
            a  = pk.done;
        end
        bus.rd_ack = a;
        @(negedge clk);
        bus.enable = 1'b0;
        bus.rd_ack = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic line(input logic lvl, input int n, input bit aod);
        bus.rxd = lvl;
        repeat (n) tick(aod);
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] b, input logic stop, input bit aod);
        line(1'b0, OSR, 1'b0);
        for (int i = 0; i < DATA_BITS; i++) line(b[i], OSR, 1'b0);
        line(stop, OSR, aod);
        bus.rxd = 1'b1;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.rxd    = 1'b1;
        bus.rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        started = 1;
        check("reset_rx_data", 32'(bus.rx_data), 32'h0);
        check("reset_rda", 32'(bus.rda), 32'h0);
        check("reset_fe", 32'(bus.framing_err), 32'h0);
        check("reset_ov", 32'(bus.overrun), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        line(1'b1, 4, 1'b0);

        // Short low pulse: start is qualified at mid-bit and rejected.
        line(1'b0, 4, 1'b0);
        line(1'b1, 2, 1'b0);
        check("glitch_busy_mid", 32'(bus.busy), 32'h1);
        line(1'b1, 12, 1'b0);
        check("glitch_busy_end", 32'(bus.busy), 32'h0);
        check("glitch_rda", 32'(bus.rda), 32'h0);

        send_frame(8'hA5, 1'b1, 1'b0);
        line(1'b1, 4, 1'b0);
        check("a5_data", 32'(bus.rx_data), 32'hA5);
        check("a5_rda", 32'(bus.rda), 32'h1);
        check("a5_fe", 32'(bus.framing_err), 32'h0);
        check("a5_ov", 32'(bus.overrun), 32'h0);
        ack_pulse();
        check("a5_ack_rda", 32'(bus.rda), 32'h0);

        send_frame(8'h3C, 1'b0, 1'b0);
        line(1'b1, 20, 1'b0);
        check("3c_data", 32'(bus.rx_data), 32'h3C);
        check("3c_rda", 32'(bus.rda), 32'h1);
        check("3c_fe", 32'(bus.framing_err), 32'h1);
        check("3c_busy", 32'(bus.busy), 32'h0);
        ack_pulse();
        check("3c_ack_rda", 32'(bus.rda), 32'h0);
        check("3c_ack_fe", 32'(bus.framing_err), 32'h0);

        line(1'b1, 4, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        line(1'b1, 4, 1'b0);
        check("b2b_data", 32'(bus.rx_data), 32'h22);
        check("b2b_rda", 32'(bus.rda), 32'h1);
        check("b2b_ov", 32'(bus.overrun), 32'h1);

        send_frame(8'h33, 1'b1, 1'b1);
        line(1'b1, 4, 1'b0);
        check("ackdone_data", 32'(bus.rx_data), 32'h33);
        check("ackdone_rda", 32'(bus.rda), 32'h1);
        check("ackdone_ov", 32'(bus.overrun), 32'h0);
        ack_pulse();

        // Reset in the middle of data bit 4 of 0xFF.
        line(1'b0, OSR, 1'b0);
        for (int i = 0; i < 4; i++) line(1'b1, OSR, 1'b0);
        line(1'b1, OSR / 2, 1'b0);
        @(negedge clk);
        rst     = 1'b1;
        bus.rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mid_data", 32'(bus.rx_data), 32'h0);
        check("rst_mid_rda", 32'(bus.rda), 32'h0);
        check("rst_mid_fe", 32'(bus.framing_err), 32'h0);
        check("rst_mid_ov", 32'(bus.overrun), 32'h0);
        check("rst_mid_busy", 32'(bus.busy), 32'h0);
        line(1'b1, 20, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        line(1'b1, 4, 1'b0);
        check("5a_data", 32'(bus.rx_data), 32'h5A);
        check("5a_rda", 32'(bus.rda), 32'h1);
        check("5a_fe", 32'(bus.framing_err), 32'h0);

        rand_ack = 1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 5) == 0) begin
                line(1'b0, $urandom_range(1, 7), 1'b0);
                line(1'b1, 12, 1'b0);
            end
            send_frame(DATA_BITS'($urandom), ($urandom_range(0, 7) != 0), 1'b0);
            line(1'b1, $urandom_range(0, 20), 1'b0);
        end
        line(1'b1, 4, 1'b0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
